// File: rtl/fixed_point_acc_pkg.sv
// Shared fixed-point package.
// Holds the accumulator FSM state encoding and the width helpers that the
// accumulator and its bus interface both need.
package fixed_point_acc_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StAccum
  } acc_state_e;

  // Headroom for MAX_TERMS full-scale terms plus a sign bit.
  function automatic int unsigned acc_width(input int unsigned width,
                                            input int unsigned max_terms);
    return width + $clog2(max_terms) + 1;
  endfunction

  // Term counter must represent 0..max_terms inclusive.
  function automatic int unsigned count_width(input int unsigned max_terms);
    return $clog2(max_terms + 1);
  endfunction

endpackage

// File: rtl/fixed_point_acc_if.sv
// Bus interface for fixed_point_acc.
// Signals:
//   start_in      request to begin an accumulation (one cycle)
//   num_terms_in  term count, sampled with start_in
//   value_in      signed operand term, qualified by valid_in
//   valid_in      operand strobe, no backpressure
//   value_out     saturated registered sum
//   valid_out     one-cycle result strobe
//   overflow_out  result was saturated, qualified by valid_out
//   busy_out      accumulation in progress
// Modports: master drives requests/operands, slave is the accumulator.
interface fixed_point_acc_if
  import fixed_point_acc_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_TERMS = 16
) ();

  localparam int unsigned CntW = count_width(MAX_TERMS);

  logic                    start_in;
  logic [CntW-1:0]         num_terms_in;
  logic signed [WIDTH-1:0] value_in;
  logic                    valid_in;
  logic signed [WIDTH-1:0] value_out;
  logic                    valid_out;
  logic                    overflow_out;
  logic                    busy_out;

  modport master (
    output start_in,
    output num_terms_in,
    output value_in,
    output valid_in,
    input  value_out,
    input  valid_out,
    input  overflow_out,
    input  busy_out
  );

  modport slave (
    input  start_in,
    input  num_terms_in,
    input  value_in,
    input  valid_in,
    output value_out,
    output valid_out,
    output overflow_out,
    output busy_out
  );

endinterface

// File: rtl/fixed_point_sat.sv
// Combinational signed saturation from IN_WIDTH down to OUT_WIDTH bits.
// Ports:
//   value_i  signed input of IN_WIDTH bits
//   value_o  signed result of OUT_WIDTH bits, clamped to the representable range
//   sat_o    high when clamping took place
// The binary point is untouched; only integer range is limited.
module fixed_point_sat #(
  parameter int unsigned IN_WIDTH  = 12,
  parameter int unsigned OUT_WIDTH = 8
) (
  input  logic signed [IN_WIDTH-1:0]  value_i,
  output logic signed [OUT_WIDTH-1:0] value_o,
  output logic                        sat_o
);

  if (IN_WIDTH > OUT_WIDTH) begin : g_narrow
    localparam logic [OUT_WIDTH-1:0] MaxVal = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] MinVal = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    // In range only when every bit from the output sign bit upward agrees.
    logic [IN_WIDTH-OUT_WIDTH:0] top_bits;
    assign top_bits = value_i[IN_WIDTH-1:OUT_WIDTH-1];

    always_comb begin
      sat_o   = !((&top_bits) || !(|top_bits));
      value_o = value_i[OUT_WIDTH-1:0];
      if (sat_o) begin
        value_o = value_i[IN_WIDTH-1] ? MinVal : MaxVal;
      end
    end
  end else begin : g_wide
    assign value_o = OUT_WIDTH'(value_i);
    assign sat_o   = 1'b0;
  end

endmodule

// File: rtl/fixed_point_acc.sv
// Fixed-point accumulator: sums a counted number of pulse-valid signed terms
// and returns a saturated, registered result with a one-cycle strobe.
// Ports:
//   clk   sole clock, rising edge
//   rstn  synchronous active-low reset
//   bus   slave side of fixed_point_acc_if (start/count/operand in,
//         value/valid/overflow/busy out)
// Input and output share the same binary point (FRAC_BITS); no rescaling.
module fixed_point_acc
  import fixed_point_acc_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned FRAC_BITS = 3,
  parameter int unsigned MAX_TERMS = 16
) (
  input logic             clk,
  input logic             rstn,
  fixed_point_acc_if.slave bus
);

  localparam int unsigned     AccW   = acc_width(WIDTH, MAX_TERMS);
  localparam int unsigned     CntW   = count_width(MAX_TERMS);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_TERMS);

  // FRAC_BITS only describes the number format; reject nonsense settings.
  if (FRAC_BITS == 0 || FRAC_BITS >= WIDTH || MAX_TERMS == 0) begin : g_bad_params
    $error("fixed_point_acc: invalid FRAC_BITS/WIDTH/MAX_TERMS");
  end

  acc_state_e              state_q, state_d;
  logic signed [AccW-1:0]  acc_q, acc_d;
  logic [CntW-1:0]         remain_q, remain_d;
  logic signed [WIDTH-1:0] value_q, value_d;
  logic                    valid_q, valid_d;
  logic                    ovf_q, ovf_d;

  logic [CntW-1:0]         num_terms_clamped;
  logic signed [AccW-1:0]  acc_sum;
  logic signed [WIDTH-1:0] sat_value;
  logic                    sat_flag;

  assign num_terms_clamped = (bus.num_terms_in > MaxCnt) ? MaxCnt : bus.num_terms_in;

  assign acc_sum = acc_q + $signed({{(AccW-WIDTH){bus.value_in[WIDTH-1]}}, bus.value_in});

  fixed_point_sat #(
    .IN_WIDTH (AccW),
    .OUT_WIDTH(WIDTH)
  ) u_sat (
    .value_i(acc_sum),
    .value_o(sat_value),
    .sat_o  (sat_flag)
  );

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    remain_d = remain_q;
    value_d  = value_q;
    ovf_d    = ovf_q;
    valid_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        // valid_in is ignored here, including in the start cycle.
        if (bus.start_in) begin
          acc_d = '0;
          if (num_terms_clamped == '0) begin
            valid_d = 1'b1;
            value_d = '0;
            ovf_d   = 1'b0;
          end else begin
            remain_d = num_terms_clamped;
            state_d  = StAccum;
          end
        end
      end
      StAccum: begin
        if (bus.valid_in) begin
          acc_d    = acc_sum;
          remain_d = remain_q - CntW'(1);
          if (remain_q == CntW'(1)) begin
            // Result is saturated straight from the final sum.
            state_d = StIdle;
            value_d = sat_value;
            ovf_d   = sat_flag;
            valid_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      remain_q <= '0;
      value_q  <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      remain_q <= remain_d;
      value_q  <= value_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.value_out    = value_q;
  assign bus.valid_out    = valid_q;
  assign bus.overflow_out = ovf_q;
  assign bus.busy_out     = (state_q == StAccum);

endmodule

// File: tb/tb_fixed_point_acc.sv
// Self-checking bench for fixed_point_acc: directed cases plus randomized
// transactions compared against an integer-arithmetic reference.
module tb_fixed_point_acc;

  localparam int unsigned WIDTH     = 8;
  localparam int unsigned FRAC_BITS = 3;
  localparam int unsigned MAX_TERMS = 16;
  localparam int unsigned CW        = $clog2(MAX_TERMS + 1);

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  fixed_point_acc_if #(.WIDTH(WIDTH), .MAX_TERMS(MAX_TERMS)) bus ();

  fixed_point_acc #(
    .WIDTH    (WIDTH),
    .FRAC_BITS(FRAC_BITS),
    .MAX_TERMS(MAX_TERMS)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] terms_q[$];

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Saturating reference: clamp the exact integer sum to WIDTH-bit range.
  function automatic int sat_ref(input int s, output bit ovf);
    int hi;
    int lo;
    hi  = (1 << (WIDTH - 1)) - 1;
    lo  = -(1 << (WIDTH - 1));
    ovf = (s > hi) || (s < lo);
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

  function automatic logic [WIDTH-1:0] rand_term();
    if ($urandom_range(3, 0) == 0) return ($urandom_range(1, 0) != 0) ? 8'h7F : 8'h80;
    return WIDTH'($urandom);
  endfunction

  // One accumulation: start with count n, feed terms (from terms_q, else random)
  // with idle gaps, then check the result. Optionally checks the cycle after.
  task automatic run_acc(input int n, input int min_gap, input int max_gap,
                         input bit start_with_valid, input bit poke_start,
                         input bit hold_after);
    int eff;
    int sum;
    int exp;
    int gap;
    bit ovf;
    logic [WIDTH-1:0] v;
    bus.start_in     = 1'b1;
    bus.num_terms_in = CW'(n);
    bus.valid_in     = start_with_valid;
    bus.value_in     = rand_term();
    tick();
    bus.start_in = 1'b0;
    bus.valid_in = 1'b0;
    eff = (n > int'(MAX_TERMS)) ? int'(MAX_TERMS) : n;
    sum = 0;
    exp = 0;
    ovf = 1'b0;
    if (eff == 0) begin
      check_eq("zero_valid", int'(bus.valid_out), 1);
      check_eq("zero_value", int'(bus.value_out), 0);
      check_eq("zero_ovf", int'(bus.overflow_out), 0);
      check_eq("zero_busy", int'(bus.busy_out), 0);
    end else begin
      check_eq("busy_start", int'(bus.busy_out), 1);
      for (int i = 0; i < eff; i++) begin
        gap = $urandom_range(max_gap, min_gap);
        for (int g = 0; g < gap; g++) begin
          bus.start_in     = poke_start;
          bus.num_terms_in = CW'($urandom_range(MAX_TERMS, 0));
          tick();
          bus.start_in = 1'b0;
          check_eq("gap_busy", int'(bus.busy_out), 1);
          check_eq("gap_valid", int'(bus.valid_out), 0);
        end
        v = (terms_q.size() > 0) ? terms_q.pop_front() : rand_term();
        bus.valid_in = 1'b1;
        bus.value_in = v;
        sum += int'($signed(v));
        tick();
        bus.valid_in = 1'b0;
        if (i < eff - 1) check_eq("mid_valid", int'(bus.valid_out), 0);
      end
      exp = sat_ref(sum, ovf);
      check_eq("res_valid", int'(bus.valid_out), 1);
      check_eq("res_value", int'(bus.value_out), exp);
      check_eq("res_ovf", int'(bus.overflow_out), int'(ovf));
      check_eq("res_busy", int'(bus.busy_out), 0);
    end
    if (hold_after) begin
      tick();
      check_eq("hold_valid", int'(bus.valid_out), 0);
      check_eq("hold_value", int'(bus.value_out), exp);
      check_eq("hold_ovf", int'(bus.overflow_out), int'(ovf));
    end
  endtask

  initial begin
    rstn             = 1'b0;
    bus.start_in     = 1'b0;
    bus.num_terms_in = '0;
    bus.value_in     = '0;
    bus.valid_in     = 1'b0;
    repeat (3) tick();
    check_eq("rst_valid", int'(bus.valid_out), 0);
    check_eq("rst_value", int'(bus.value_out), 0);
    check_eq("rst_ovf", int'(bus.overflow_out), 0);
    check_eq("rst_busy", int'(bus.busy_out), 0);
    rstn = 1'b1;
    tick();

    // Operands while idle are ignored.
    for (int i = 0; i < 4; i++) begin
      bus.valid_in = 1'b1;
      bus.value_in = rand_term();
      tick();
      check_eq("idle_valid", int'(bus.valid_out), 0);
      check_eq("idle_busy", int'(bus.busy_out), 0);
      check_eq("idle_value", int'(bus.value_out), 0);
    end
    bus.valid_in = 1'b0;

    // 4 x 1.0 -> 4.0 (0x20).
    terms_q = '{8'h08, 8'h08, 8'h08, 8'h08};
    run_acc(4, 0, 0, 1'b0, 1'b0, 1'b1);
    // 2.0 - 2.0 + 0.5 with idle gaps.
    terms_q = '{8'h10, 8'hF0, 8'h04};
    run_acc(3, 2, 5, 1'b0, 1'b0, 1'b1);
    // Positive and negative saturation.
    for (int i = 0; i < 16; i++) terms_q.push_back(8'h7F);
    run_acc(16, 0, 1, 1'b0, 1'b0, 1'b1);
    terms_q = '{8'h80, 8'h80, 8'h80};
    run_acc(3, 0, 1, 1'b0, 1'b0, 1'b1);
    // Zero-term request, then a start whose same-cycle operand is dropped.
    run_acc(0, 0, 0, 1'b0, 1'b0, 1'b1);
    terms_q = '{8'h03, 8'h04};
    run_acc(2, 0, 1, 1'b1, 1'b0, 1'b1);
    // Oversized count is clamped.
    run_acc(31, 0, 1, 1'b0, 1'b0, 1'b1);

    // Reset mid-accumulation abandons the sum.
    bus.start_in     = 1'b1;
    bus.num_terms_in = CW'(4);
    tick();
    bus.start_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.valid_in = 1'b1;
      bus.value_in = 8'h11;
      tick();
    end
    bus.valid_in = 1'b0;
    rstn = 1'b0;
    tick();
    check_eq("mrst_valid", int'(bus.valid_out), 0);
    check_eq("mrst_busy", int'(bus.busy_out), 0);
    check_eq("mrst_value", int'(bus.value_out), 0);
    rstn = 1'b1;
    tick();
    check_eq("mrst_after_valid", int'(bus.valid_out), 0);
    terms_q = '{8'h05};
    run_acc(1, 0, 0, 1'b0, 1'b0, 1'b1);

    // Start pokes during accumulation are ignored; back-to-back start accepted.
    terms_q = '{8'h01, 8'h02, 8'h03};
    run_acc(3, 1, 3, 1'b0, 1'b1, 1'b0);
    terms_q = '{8'h10, 8'h20};
    run_acc(2, 0, 2, 1'b0, 1'b0, 1'b1);

    // Randomized transactions.
    for (int k = 0; k < 40; k++) begin
      run_acc($urandom_range(20, 0), 0, $urandom_range(3, 0),
              1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
              1'($urandom_range(1, 0)));
    end
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
